vector_ls_sequencer: RTL and testbench

Sequences the scalar-word memory transfers behind a vector load/store: on a `new_op` pulse it expands one vector operation into `count` word requests on the data-memory bus. For stores it reads slice data; for loads it writes returned data into the vector register slices. It pulses `complete` to the vector load/store control FSM. It sits between that FSM's control interface and the shared data-memory port, with bounded outstanding requests and in-order responses.

---
 rtl/vector_ls_sequencer_pkg.sv | 31 +++
 rtl/vector_ls_sequencer_if.sv | 24 ++
 rtl/vector_ls_sequencer_credit.sv | 36 +++
 rtl/vector_ls_sequencer.sv | 121 ++++++++++++
 tb/tb_vector_ls_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_ls_sequencer_pkg.sv
// Shared types and sizing helpers for the vector load/store path.
// The load/store control FSM sizes its counters with the same functions.
package vector_ls_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } Seq_state;

  function automatic int word_bytes(input int scalar_size);
    return scalar_size / 8;
  endfunction

  localparam int WORD_BYTES = word_bytes(32);

  function automatic int num_scalars(input int num_slices, input int num_elems,
                                     input int elem_size, input int scalar_size);
    return num_elems * elem_size / scalar_size * num_slices;
  endfunction

  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int iw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_ls_sequencer_if.sv
// Data-memory port between the sequencer (master) and the shared bus (slave).
// A request transfers on a rising clk edge where req_valid && req_ready; once raised, req_valid and
// the request fields hold until that edge. Responses arrive in request order, one per resp_valid cycle.
interface vector_ls_sequencer_if #(
  parameter int SCALAR_SIZE = 32
) ();
  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic                   req_we;
  logic [SCALAR_SIZE-1:0] req_wdata;
  logic                   resp_valid;
  logic [SCALAR_SIZE-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/vector_ls_sequencer_credit.sv
// Up/down count of issued-but-unanswered bus requests.
// A decrement at zero is dropped and flagged instead of wrapping.
module ls_credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         underflow_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         dec_ok;

  assign dec_ok      = dec_i && (cnt_q != '0);
  assign underflow_o = dec_i && (cnt_q == '0);
  assign full_o      = (cnt_q == W'(MAX_OUTSTANDING));
  assign cnt_o       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_ok})
      2'b10:   cnt_d = cnt_q + W'(1);
      2'b01:   cnt_d = cnt_q - W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vector_ls_sequencer.sv
// Expands one vector load/store into count scalar word requests on the data-memory port,
// moving store data out of the slices and load data back into them, then pulses complete.
module vector_ls_sequencer
  import vector_ls_pkg::*;
#(
  parameter int NUM_SLICES      = 1,
  parameter int NUM_ELEMS       = 8,
  parameter int ELEM_SIZE       = 16,
  parameter int SCALAR_SIZE     = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int NUM_SCALARS    = num_scalars(NUM_SLICES, NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE),
  localparam int CW             = cw_of(NUM_SCALARS),
  localparam int IW             = iw_of(NUM_SCALARS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_op,
  input  logic                   we,
  input  logic [CW-1:0]          count,
  input  logic [31:0]            g,
  output logic                   complete,
  output logic                   busy,
  output logic                   protocol_err,
  vector_ls_sequencer_if.master  mem,
  output logic [IW-1:0]          vec_rd_idx,
  input  logic [SCALAR_SIZE-1:0] vec_rd_data,
  output logic                   vec_wr_en,
  output logic [IW-1:0]          vec_wr_idx,
  output logic [SCALAR_SIZE-1:0] vec_wr_data,
  output Seq_state               state_dbg_o
);
  localparam int WB = word_bytes(SCALAR_SIZE);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  Seq_state               state_q, state_d;
  logic [31:0]            g_q;
  logic [CW-1:0]          count_q, issued_q, received_q;
  logic                   we_q, err_q;
  logic                   wr_en_q;
  logic [IW-1:0]          wr_idx_q;
  logic [SCALAR_SIZE-1:0] wr_data_q;

  logic [OW-1:0] out_cnt;
  logic          out_full, out_underflow;
  logic          req_valid_c, req_fire, resp_ok, start;

  ls_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .W(OW)) u_credit (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (req_fire),
    .dec_i      (mem.resp_valid),
    .cnt_o      (out_cnt),
    .full_o     (out_full),
    .underflow_o(out_underflow)
  );

  assign start       = (state_q == IDLE) && new_op;
  assign req_valid_c = (state_q == ISSUE) && (issued_q < count_q) && !out_full;
  assign req_fire    = req_valid_c && mem.req_ready;
  // A response with nothing outstanding (e.g. left over from before a reset) is dropped.
  assign resp_ok     = mem.resp_valid && !out_underflow;

  // Request fields are zero while idle; they only depend on registered state, so they hold during a stall.
  assign mem.req_valid = req_valid_c;
  assign mem.req_addr  = req_valid_c ? (g_q + 32'(issued_q) * 32'(WB)) : '0;
  assign mem.req_we    = req_valid_c ? we_q : 1'b0;
  assign mem.req_wdata = req_valid_c ? vec_rd_data : '0;
  assign vec_rd_idx    = issued_q[IW-1:0];

  assign complete     = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign protocol_err = err_q;
  assign vec_wr_en    = wr_en_q;
  assign vec_wr_idx   = wr_idx_q;
  assign vec_wr_data  = wr_data_q;
  assign state_dbg_o  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_op) state_d = (count == '0) ? DONE : ISSUE;
      ISSUE:   if (req_fire && (issued_q + CW'(1) == count_q)) state_d = DRAIN;
      DRAIN:   if (resp_ok && (received_q + CW'(1) == count_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      g_q        <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      issued_q   <= '0;
      received_q <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        g_q        <= g;
        count_q    <= count;
        we_q       <= we;
        issued_q   <= '0;
        received_q <= '0;
      end else begin
        if (req_fire) issued_q   <= issued_q + CW'(1);
        if (resp_ok)  received_q <= received_q + CW'(1);
      end
      if ((new_op && state_q != IDLE) || (mem.resp_valid && out_underflow)) err_q <= 1'b1;
      wr_en_q <= resp_ok && !we_q;
      if (resp_ok && !we_q) begin
        wr_idx_q  <= received_q[IW-1:0];
        wr_data_q <= mem.resp_rdata;
      end
    end
  end
endmodule

// File: tb/tb_vector_ls_sequencer.sv
// Bench for vector_ls_sequencer: directed table plus randomized ops against a transaction-level model
// of the memory port and slices, followed by hand-written error/reset sequences.
module tb_vector_ls_sequencer;
  import vector_ls_pkg::*;

  localparam int MAX_OUT = 4;

  typedef struct {
    logic        we;
    int          count;
    logic [31:0] g;
    int          ready_mode;     // 0 always ready, 1 ready on even cycles, 2 random
    int          lat;            // response latency, 0 = random per request
    int          withhold_until; // no responses before this cycle
    int          inject_cyc;     // cycle at which a stray new_op is driven, 0 = none
    int          exp_complete;   // -1 = derive from the model only
    logic [31:0] exp_last_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_op, we;
  logic [3:0]  count;
  logic [31:0] g;
  logic        complete, busy, protocol_err;
  logic [2:0]  vec_rd_idx, vec_wr_idx;
  logic [31:0] vec_rd_data, vec_wr_data;
  logic        vec_wr_en;
  Seq_state    state_dbg;
  logic [31:0] slice_mem [8];

  int          n_checks = 0;
  int          n_fail = 0;
  logic        err_expected = 1'b0;
  logic [31:0] exp_q[$];
  vec_t        tbl [6];
  vec_t        v;

  vector_ls_sequencer_if #(.SCALAR_SIZE(32)) mem_if ();

  vector_ls_sequencer #(
    .NUM_SLICES(1), .NUM_ELEMS(16), .ELEM_SIZE(16), .SCALAR_SIZE(32), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .new_op      (new_op),
    .we          (we),
    .count       (count),
    .g           (g),
    .complete    (complete),
    .busy        (busy),
    .protocol_err(protocol_err),
    .mem         (mem_if),
    .vec_rd_idx  (vec_rd_idx),
    .vec_rd_data (vec_rd_data),
    .vec_wr_en   (vec_wr_en),
    .vec_wr_idx  (vec_wr_idx),
    .vec_wr_data (vec_wr_data),
    .state_dbg_o (state_dbg)
  );

  // clock / slice read port
  always #5 clk = ~clk;
  assign vec_rd_data = slice_mem[vec_rd_idx];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_complete"}, 32'(complete), 32'd0);
    check({tag, "_req_valid"}, 32'(mem_if.req_valid), 32'd0);
    check({tag, "_vec_wr_en"}, 32'(vec_wr_en), 32'd0);
  endtask

  // driver + model for one vector operation
  task automatic run_op(input vec_t t);
    int          issued, received, out_prev, last_resp, complete_cyc, lat, cyc;
    bit          done, prev_stall, exp_rv, exp_en, exp_cmp;
    logic [31:0] prev_addr, prev_wdata, last_addr;
    logic        prev_we;
    logic [2:0]  prev_idx;
    int          due_q[$];
    logic [31:0] rdata_q[$];
    int          ew_cyc_q[$];
    logic [2:0]  ew_idx_q[$];
    logic [31:0] ew_data_q[$];

    issued = 0; received = 0; last_resp = -10; complete_cyc = -1;
    done = 0; prev_stall = 0; last_addr = '0;
    prev_addr = '0; prev_wdata = '0; prev_we = 1'b0; prev_idx = '0;
    exp_q.delete();
    for (int i = 0; i < t.count; i++) exp_q.push_back(t.g + 32'(i) * 32'd4);

    @(negedge clk);
    new_op = 1'b1; we = t.we; count = 4'(t.count); g = t.g;
    mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b0;
    #1;
    check("start_req_valid", 32'(mem_if.req_valid), 32'd0);

    for (cyc = 1; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == t.inject_cyc) begin
        new_op = 1'b1; we = 1'b1; count = 4'd1; g = 32'h0;
      end else begin
        new_op = 1'b0;
      end
      case (t.ready_mode)
        0:       mem_if.req_ready = 1'b1;
        1:       mem_if.req_ready = (cyc % 2 == 0);
        default: mem_if.req_ready = ($urandom_range(0, 3) != 0);
      endcase
      out_prev = issued - received;
      exp_rv   = (issued < t.count) && (out_prev < MAX_OUT);
      mem_if.resp_valid = 1'b0;
      mem_if.resp_rdata = $urandom;
      if (due_q.size() > 0 && due_q[0] <= cyc && cyc >= t.withhold_until) begin
        if (t.withhold_until > 0 && received == 0)
          check("withheld_issue_count", 32'(issued), 32'((t.count < MAX_OUT) ? t.count : MAX_OUT));
        mem_if.resp_valid = 1'b1;
        mem_if.resp_rdata = rdata_q.pop_front();
        void'(due_q.pop_front());
        if (!t.we) begin
          ew_cyc_q.push_back(cyc + 1);
          ew_idx_q.push_back(3'(received));
          ew_data_q.push_back(mem_if.resp_rdata);
        end
        received++;
        last_resp = cyc;
      end
      #1;
      check("req_valid", 32'(mem_if.req_valid), 32'(exp_rv));
      check("busy", 32'(busy), 32'd1);
      if (prev_stall) begin
        check("held_req_valid", 32'(mem_if.req_valid), 32'd1);
        check("held_req_addr", mem_if.req_addr, prev_addr);
        check("held_req_we", 32'(mem_if.req_we), 32'(prev_we));
        check("held_req_wdata", mem_if.req_wdata, prev_wdata);
        check("held_vec_rd_idx", 32'(vec_rd_idx), 32'(prev_idx));
      end
      if (mem_if.req_valid) check("vec_rd_idx", 32'(vec_rd_idx), 32'(issued % 8));
      if (mem_if.req_valid && mem_if.req_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_handshake", 32'(issued), 32'(t.count));
        end else begin
          last_addr = exp_q.pop_front();
          check("req_addr", mem_if.req_addr, last_addr);
        end
        check("req_we", 32'(mem_if.req_we), 32'(t.we));
        if (t.we) check("req_wdata", mem_if.req_wdata, slice_mem[issued % 8]);
        lat = (t.lat > 0) ? t.lat : $urandom_range(1, 6);
        due_q.push_back(cyc + lat);
        rdata_q.push_back($urandom);
        issued++;
      end
      exp_en = (ew_cyc_q.size() > 0) && (ew_cyc_q[0] == cyc);
      check("vec_wr_en", 32'(vec_wr_en), 32'(exp_en));
      if (exp_en) begin
        void'(ew_cyc_q.pop_front());
        check("vec_wr_idx", 32'(vec_wr_idx), 32'(ew_idx_q.pop_front()));
        check("vec_wr_data", vec_wr_data, ew_data_q.pop_front());
      end
      exp_cmp = (t.count == 0) ? (cyc == 1) : (received == t.count && last_resp == cyc - 1);
      check("complete", 32'(complete), 32'(exp_cmp));
      if (complete) begin
        done = 1;
        complete_cyc = cyc;
      end
      prev_stall = mem_if.req_valid && !mem_if.req_ready;
      prev_addr  = mem_if.req_addr;
      prev_we    = mem_if.req_we;
      prev_wdata = mem_if.req_wdata;
      prev_idx   = vec_rd_idx;
    end

    check("complete_seen", 32'(done), 32'd1);
    if (t.exp_complete >= 0) check("complete_cycle", 32'(complete_cyc), 32'(t.exp_complete));
    check("all_issued", 32'(issued), 32'(t.count));
    check("writes_drained", 32'(ew_cyc_q.size()), 32'd0);
    if (t.count > 0) check("last_addr", last_addr, t.exp_last_addr);
    if (t.inject_cyc > 0) err_expected = 1'b1;

    @(negedge clk);
    new_op = 1'b0; mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b0;
    #1;
    check_quiet_outputs("after_op");
    check("protocol_err", 32'(protocol_err), 32'(err_expected));
  endtask

  initial begin
    reset = 1'b1; new_op = 1'b0; we = 1'b0; count = '0; g = '0;
    mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b0; mem_if.resp_rdata = '0;
    for (int i = 0; i < 8; i++) slice_mem[i] = $urandom;

    tbl[0] = '{1'b0, 8, 32'h0000_1000, 0, 2, 0,  0, 11, 32'h0000_101C};
    tbl[1] = '{1'b1, 4, 32'h0000_0400, 1, 2, 0,  0, 11, 32'h0000_040C};
    tbl[2] = '{1'b0, 8, 32'h0000_2000, 0, 2, 11, 0, 19, 32'h0000_201C};
    tbl[3] = '{1'b1, 0, 32'h0000_5000, 0, 2, 0,  0, 1,  32'h0000_0000};
    tbl[4] = '{1'b0, 4, 32'hFFFF_FFF8, 0, 2, 0,  0, 7,  32'h0000_0004};
    tbl[5] = '{1'b0, 4, 32'h0000_2000, 0, 2, 0,  2, 7,  32'h0000_200C};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_quiet_outputs("reset");
    check("reset_req_addr", mem_if.req_addr, 32'd0);
    check("reset_req_wdata", mem_if.req_wdata, 32'd0);
    check("reset_vec_rd_idx", 32'(vec_rd_idx), 32'd0);
    check("reset_protocol_err", 32'(protocol_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    for (int i = 0; i < 12; i++) begin
      v.we             = 1'($urandom_range(0, 1));
      v.count          = $urandom_range(0, 8);
      v.g              = $urandom;
      v.ready_mode     = 2;
      v.lat            = 0;
      v.withhold_until = 0;
      v.inject_cyc     = 0;
      v.exp_complete   = -1;
      v.exp_last_addr  = v.g + 32'(v.count - 1) * 32'd4;
      run_op(v);
    end

    // reset in the middle of a load, then a stray response
    @(negedge clk);
    new_op = 1'b1; we = 1'b0; count = 4'd8; g = 32'h0000_3000;
    mem_if.req_ready = 1'b1; mem_if.resp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      new_op = 1'b0;
    end
    #1;
    check("midop_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet_outputs("midop_reset");
    check("midop_reset_req_addr", mem_if.req_addr, 32'd0);
    check("midop_reset_vec_rd_idx", 32'(vec_rd_idx), 32'd0);
    check("midop_reset_protocol_err", 32'(protocol_err), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_if.req_ready = 1'b0;
    @(negedge clk);
    mem_if.resp_valid = 1'b1; mem_if.resp_rdata = 32'hDEAD_BEEF;
    #1;
    check("stray_vec_wr_en_same", 32'(vec_wr_en), 32'd0);
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    #1;
    check_quiet_outputs("stray_resp");
    check("stray_protocol_err", 32'(protocol_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
